// File: rtl/nv_pwr_gate_seq.sv
// nv_pwr_gate_seq
// ---------------------------------------------------------------------------
// Power-gating sequencer for a switchable power domain. It orders the
// isolation clamp, the domain reset and the power-switch chain request so
// that the domain is always isolated and held in reset while it is unpowered.
//
// Ports:
//   nvdla_core_clk   in   single clock, all flops rise-edge
//   nvdla_core_rstn  in   asynchronous active-low reset
//   pwr_off_req      in   level request: 1 = power domain down, 0 = power up
//   pg_ack           in   asynchronous ack from the tail of the switch chain
//   pwr_err_clr      in   single-cycle pulse clearing pwr_err
//   pg_sleep         out  head of switch chain, 1 = switches off
//   iso_en           out  output isolation clamp enable
//   dom_rstn         out  domain reset, active-low
//   pwr_status       out  1 = domain stably off
//   pwr_busy         out  1 = sequencing (any state other than ON / OFF)
//   pwr_err          out  sticky ack-timeout flag
//   dbg_state        out  current FSM state encoding, for observation only
//
// Handshake: pwr_off_req is a level, not a valid/ready pair. The sequencer
// acknowledges it only through state: pwr_status=1 with pwr_busy=0 means the
// domain is off; pwr_status=0 with pwr_busy=0 means it is on.
module nv_pwr_gate_seq #(
    parameter int unsigned ISO_DLY = 4,
    parameter int unsigned RST_CYC = 8,
    parameter int unsigned ACK_TO  = 16
) (
    input  logic       nvdla_core_clk,
    input  logic       nvdla_core_rstn,
    input  logic       pwr_off_req,
    input  logic       pg_ack,
    input  logic       pwr_err_clr,
    output logic       pg_sleep,
    output logic       iso_en,
    output logic       dom_rstn,
    output logic       pwr_status,
    output logic       pwr_busy,
    output logic       pwr_err,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_RST      = 3'd0,
        S_DEISO    = 3'd1,
        S_ON       = 3'd2,
        S_ISO      = 3'd3,
        S_PG_REQ   = 3'd4,
        S_OFF      = 3'd5,
        S_WAKE_REQ = 3'd6
    } state_t;

    // The counter reads 0 on the first cycle of a state, so "N cycles in a
    // state" means leaving when the counter reaches N-1.
    localparam logic [9:0] ISO_LAST = 10'(ISO_DLY - 1);
    localparam logic [9:0] RST_LAST = 10'(RST_CYC - 1);
    localparam logic [9:0] ACK_LAST = 10'(ACK_TO - 1);
    localparam logic [9:0] CNT_MAX  = 10'h3ff;

    state_t     state;
    state_t     state_nxt;
    logic [9:0] cnt;
    logic       cnt_restart;
    logic       err_set;
    logic       ack_meta;
    logic       ack_s;

    // Output decode {pg_sleep, iso_en, dom_rstn, pwr_status, pwr_busy}.
    function automatic logic [4:0] decode(input state_t s);
        logic [4:0] v;
        v = 5'b01001;
        case (s)
            S_RST:      v = 5'b01001;
            S_DEISO:    v = 5'b01101;
            S_ON:       v = 5'b00100;
            S_ISO:      v = 5'b01001;
            S_PG_REQ:   v = 5'b11001;
            S_OFF:      v = 5'b11010;
            S_WAKE_REQ: v = 5'b01001;
            default:    v = 5'b01001;
        endcase
        return v;
    endfunction

    // Two-flop synchronizer for the chain ack; only ack_s feeds decisions.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= pg_ack;
            ack_s    <= ack_meta;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_restart = 1'b0;
        err_set     = 1'b0;
        case (state)
            S_RST: begin
                if (cnt >= RST_LAST) state_nxt = S_DEISO;
            end
            S_DEISO: begin
                // A request that is already up when de-isolation finishes
                // goes straight back into isolation instead of through ON.
                if (cnt >= ISO_LAST) state_nxt = pwr_off_req ? S_ISO : S_ON;
            end
            S_ON: begin
                if (pwr_off_req) state_nxt = S_ISO;
            end
            S_ISO: begin
                // Request withdrawn while only isolated: nothing was powered
                // down yet, so simply de-isolate again.
                if (!pwr_off_req)          state_nxt = S_DEISO;
                else if (cnt >= ISO_LAST)  state_nxt = S_PG_REQ;
            end
            S_PG_REQ: begin
                // pwr_off_req is deliberately ignored here: the chain must
                // settle one way or the other before we reverse it.
                if (ack_s) begin
                    state_nxt = S_OFF;
                end else if (cnt >= ACK_LAST) begin
                    err_set   = 1'b1;
                    state_nxt = S_WAKE_REQ;
                end
            end
            S_OFF: begin
                if (!pwr_off_req) state_nxt = S_WAKE_REQ;
            end
            S_WAKE_REQ: begin
                // Never leave while the chain still reports off; a timeout
                // only flags the error and restarts the wait.
                if (!ack_s) begin
                    state_nxt = S_RST;
                end else if (cnt >= ACK_LAST) begin
                    err_set     = 1'b1;
                    cnt_restart = 1'b1;
                end
            end
            default: state_nxt = S_RST;
        endcase
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state      <= S_RST;
            cnt        <= 10'd0;
            pg_sleep   <= 1'b0;
            iso_en     <= 1'b1;
            dom_rstn   <= 1'b0;
            pwr_status <= 1'b0;
            pwr_busy   <= 1'b1;
            pwr_err    <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state_nxt != state) || cnt_restart) begin
                cnt <= 10'd0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 10'd1;
            end
            // Outputs are decoded from the next state so they are plain flop
            // outputs that change on the same edge as the state register.
            {pg_sleep, iso_en, dom_rstn, pwr_status, pwr_busy} <= decode(state_nxt);
            if (err_set) begin
                pwr_err <= 1'b1;
            end else if (pwr_err_clr) begin
                pwr_err <= 1'b0;
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_nv_pwr_gate_seq.sv
// Testbench for nv_pwr_gate_seq (default parameters).
// Observed vector per cycle: {pg_sleep, iso_en, dom_rstn, pwr_status,
// pwr_busy, pwr_err}. Each scenario pushes the expected per-cycle vectors
// into exp_q, then pops one per falling edge and compares.
module tb_nv_pwr_gate_seq;

    localparam logic [5:0] V_RST   = 6'b010010;
    localparam logic [5:0] V_DEISO = 6'b011010;
    localparam logic [5:0] V_ON    = 6'b001000;
    localparam logic [5:0] V_ISO   = 6'b010010;
    localparam logic [5:0] V_PG    = 6'b110010;
    localparam logic [5:0] V_OFF   = 6'b110100;
    localparam logic [5:0] V_WAKE  = 6'b010010;
    localparam logic [5:0] E       = 6'b000001;

    localparam int ACK_FOLLOW = 0;
    localparam int ACK_STUCK0 = 1;
    localparam int ACK_STUCK1 = 2;

    logic       clk = 1'b0;
    logic       rstn;
    logic       pwr_off_req;
    logic       pg_ack = 1'b0;
    logic       pwr_err_clr;
    logic       pg_sleep;
    logic       iso_en;
    logic       dom_rstn;
    logic       pwr_status;
    logic       pwr_busy;
    logic       pwr_err;
    logic [2:0] dbg_state;
    logic [5:0] obs_v;

    logic [5:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         ack_mode = ACK_FOLLOW;
    logic       ack_d0 = 1'b0;
    logic       ack_d1 = 1'b0;

    nv_pwr_gate_seq dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .pwr_off_req     (pwr_off_req),
        .pg_ack          (pg_ack),
        .pwr_err_clr     (pwr_err_clr),
        .pg_sleep        (pg_sleep),
        .iso_en          (iso_en),
        .dom_rstn        (dom_rstn),
        .pwr_status      (pwr_status),
        .pwr_busy        (pwr_busy),
        .pwr_err         (pwr_err),
        .dbg_state       (dbg_state)
    );

    assign obs_v = {pg_sleep, iso_en, dom_rstn, pwr_status, pwr_busy, pwr_err};

    // Clock / reset block
    always #5 clk = ~clk;

    // Switch-chain model: ack follows pg_sleep three clocks later, or is
    // forced stuck for the timeout scenarios.
    always @(posedge clk) begin
        ack_d0 <= pg_sleep;
        ack_d1 <= ack_d0;
        case (ack_mode)
            ACK_FOLLOW: pg_ack <= ack_d1;
            ACK_STUCK0: pg_ack <= 1'b0;
            default:    pg_ack <= 1'b1;
        endcase
    end

    function automatic void push_n(input logic [5:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endfunction

    task automatic test_reset();
        rstn        = 1'b0;
        pwr_off_req = 1'b0;
        pwr_err_clr = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (obs_v !== V_RST) begin
                errors++;
                $display("FAIL reset_state got %b exp %b", obs_v, V_RST);
            end
        end
    endtask

    task automatic test_power_on();
        int n;
        rstn = 1'b1;
        push_n(V_RST, 7);
        push_n(V_DEISO, 4);
        push_n(V_ON, 3);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            logic [5:0] ev;
            @(negedge clk);
            ev = exp_q.pop_front();
            checks++;
            if (obs_v !== ev) begin
                errors++;
                $display("FAIL power_on cyc %0d got %b exp %b", i, obs_v, ev);
            end
        end
    endtask

    task automatic test_power_down();
        int n;
        pwr_off_req = 1'b1;
        push_n(V_ISO, 4);
        push_n(V_PG, 6);
        push_n(V_OFF, 3);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            logic [5:0] ev;
            @(negedge clk);
            ev = exp_q.pop_front();
            checks++;
            if (obs_v !== ev) begin
                errors++;
                $display("FAIL power_down cyc %0d got %b exp %b", i, obs_v, ev);
            end
        end
    endtask

    task automatic test_wake();
        int n;
        pwr_off_req = 1'b0;
        push_n(V_WAKE, 6);
        push_n(V_RST, 8);
        push_n(V_DEISO, 4);
        push_n(V_ON, 3);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            logic [5:0] ev;
            @(negedge clk);
            ev = exp_q.pop_front();
            checks++;
            if (obs_v !== ev) begin
                errors++;
                $display("FAIL wake cyc %0d got %b exp %b", i, obs_v, ev);
            end
        end
    endtask

    // Ack stuck low in PG_REQ. pwr_err_clr is held high the whole time, so
    // the error must appear on the timeout edge (set beats clear) and vanish
    // on the next one. The request is dropped inside PG_REQ and must not
    // shorten the wait.
    task automatic test_pg_timeout();
        int n;
        ack_mode    = ACK_STUCK0;
        pwr_off_req = 1'b1;
        pwr_err_clr = 1'b1;
        push_n(V_ISO, 4);
        push_n(V_PG, 16);
        push_n(V_WAKE | E, 1);
        push_n(V_RST, 8);
        push_n(V_DEISO, 4);
        push_n(V_ON, 2);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            logic [5:0] ev;
            @(negedge clk);
            ev = exp_q.pop_front();
            checks++;
            if (obs_v !== ev) begin
                errors++;
                $display("FAIL pg_timeout cyc %0d got %b exp %b", i, obs_v, ev);
            end
            if (i == 4) pwr_off_req = 1'b0;
        end
        pwr_err_clr = 1'b0;
        ack_mode    = ACK_FOLLOW;
    endtask

    // Ack stuck high in WAKE_REQ: error after 16 cycles, no exit until the
    // ack drops; error survives the wake and is then cleared by one pulse.
    task automatic test_wake_timeout();
        int n;
        pwr_off_req = 1'b1;
        push_n(V_ISO, 4);
        push_n(V_PG, 6);
        push_n(V_OFF, 3);
        push_n(V_WAKE, 16);
        push_n(V_WAKE | E, 4);
        push_n(V_RST | E, 8);
        push_n(V_DEISO | E, 4);
        push_n(V_ON | E, 2);
        push_n(V_ON, 3);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            logic [5:0] ev;
            @(negedge clk);
            ev = exp_q.pop_front();
            checks++;
            if (obs_v !== ev) begin
                errors++;
                $display("FAIL wake_timeout cyc %0d got %b exp %b", i, obs_v, ev);
            end
            if (i == 12) begin
                ack_mode    = ACK_STUCK1;
                pwr_off_req = 1'b0;
            end
            if (i == 29) ack_mode = ACK_FOLLOW;
            if (i == 46) pwr_err_clr = 1'b1;
            if (i == 47) pwr_err_clr = 1'b0;
        end
    endtask

    task automatic test_abort();
        int n;
        pwr_off_req = 1'b1;
        push_n(V_ISO, 1);
        push_n(V_DEISO, 4);
        push_n(V_ON, 3);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            logic [5:0] ev;
            @(negedge clk);
            ev = exp_q.pop_front();
            checks++;
            if (obs_v !== ev) begin
                errors++;
                $display("FAIL abort cyc %0d got %b exp %b", i, obs_v, ev);
            end
            if (i == 0) pwr_off_req = 1'b0;
        end
    endtask

    // Reach OFF, then pull reset between clock edges: outputs must change
    // without a clock edge.
    task automatic test_reset_in_off();
        int n;
        pwr_off_req = 1'b1;
        push_n(V_ISO, 4);
        push_n(V_PG, 6);
        push_n(V_OFF, 3);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            logic [5:0] ev;
            @(negedge clk);
            ev = exp_q.pop_front();
            checks++;
            if (obs_v !== ev) begin
                errors++;
                $display("FAIL reset_in_off cyc %0d got %b exp %b", i, obs_v, ev);
            end
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (obs_v !== V_RST) begin
            errors++;
            $display("FAIL async_reset got %b exp %b", obs_v, V_RST);
        end
        @(negedge clk);
    endtask

    // Reset released with the request already high: DEISO must hand over
    // to ISO, complete a full power-down, then wake straight back up.
    task automatic test_back_to_back();
        int n;
        rstn = 1'b1;
        push_n(V_RST, 7);
        push_n(V_DEISO, 4);
        push_n(V_ISO, 4);
        push_n(V_PG, 6);
        push_n(V_OFF, 3);
        push_n(V_WAKE, 6);
        push_n(V_RST, 8);
        push_n(V_DEISO, 4);
        push_n(V_ON, 3);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            logic [5:0] ev;
            @(negedge clk);
            ev = exp_q.pop_front();
            checks++;
            if (obs_v !== ev) begin
                errors++;
                $display("FAIL back_to_back cyc %0d got %b exp %b", i, obs_v, ev);
            end
            if (i == 23) pwr_off_req = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_power_on();
        test_power_down();
        test_wake();
        test_pg_timeout();
        test_wake_timeout();
        test_abort();
        test_reset_in_off();
        test_back_to_back();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nv_pwr_gate_seq.md
NV_PWR_GATE_SEQ -- requirements
Module: nv_pwr_gate_seq

Interface
REQ-001 SHALL have parameter ISO_DLY, default 4: cycles spent in each isolation-settle state (ISO, DEISO), range 1..255.
REQ-002 SHALL have parameter RST_CYC, default 8: cycles domain reset is held in RST, range 1..255.
REQ-003 SHALL have parameter ACK_TO, default 16: cycles allowed for the synchronized ack to match pg_sleep, range 2..1023.
REQ-004 SHALL have port nvdla_core_clk  in  1  the single clock; all flops rise-edge.
REQ-005 SHALL have port nvdla_core_rstn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port pwr_off_req  in  1  level request: 1 = power domain down, 0 = power up.
REQ-007 SHALL have port pg_ack  in  1  asynchronous return from tail of power-switch daisy chain.
REQ-008 SHALL have port pwr_err_clr  in  1  single-cycle pulse clearing pwr_err.
REQ-009 SHALL have port pg_sleep  out  1  drives head of power-switch chain; 1 = switches off.
REQ-010 SHALL have port iso_en  out  1  domain output isolation clamp enable.
REQ-011 SHALL have port dom_rstn  out  1  domain reset, active-low.
REQ-012 SHALL have port pwr_status  out  1  1 = domain stably off (state OFF).
REQ-013 SHALL have port pwr_busy  out  1  1 = any state other than ON or OFF.
REQ-014 SHALL have port pwr_err  out  1  sticky ack-timeout flag.

Function
REQ-015 SHALL synchronize pg_ack through two flops (ack_s); decisions use ack_s only.
REQ-016 SHALL implement states RST, DEISO, ON, ISO, PG_REQ, OFF, WAKE_REQ; all outputs registered, decoded from state.
REQ-017 SHALL drive per state (pg_sleep/iso_en/dom_rstn): RST 0/1/0, DEISO 0/1/1, ON 0/0/1, ISO 0/1/0, PG_REQ 1/1/0, OFF 1/1/0, WAKE_REQ 0/1/0.
REQ-018 SHALL use one shared cycle counter, cleared on every state entry.
REQ-019 RST SHALL go to DEISO after RST_CYC cycles in RST.
REQ-020 DEISO SHALL go to ON after ISO_DLY cycles, except when pwr_off_req=1 on the final cycle, in which case it goes to ISO.
REQ-021 ON SHALL go to ISO in the cycle after pwr_off_req is sampled 1.
REQ-022 ISO SHALL go to DEISO if pwr_off_req is sampled 0 before ISO_DLY cycles elapse (abort); otherwise it goes to PG_REQ after ISO_DLY cycles.
REQ-023 PG_REQ SHALL go to OFF on the first cycle ack_s=1.
REQ-024 PG_REQ SHALL, if ACK_TO cycles elapse with ack_s=0, set pwr_err and go to WAKE_REQ (abort power-down).
REQ-025 PG_REQ SHALL ignore pwr_off_req deassertion; the sequence completes first.
REQ-026 OFF SHALL go to WAKE_REQ in the cycle after pwr_off_req is sampled 0.
REQ-027 WAKE_REQ SHALL go to RST on the first cycle ack_s=0.
REQ-028 WAKE_REQ SHALL, on ACK_TO expiry, set pwr_err and remain in WAKE_REQ (counter restarts) until ack_s=0; reset is never released on an unpowered domain.
REQ-029 pwr_err SHALL be set by a timeout and cleared by pwr_err_clr; set wins over a same-cycle clear.
REQ-030 pwr_err SHALL NOT block requests.
REQ-031 The counter SHALL be 10 bits and SHALL saturate rather than wrap.
REQ-032 pg_sleep and iso_en SHALL be glitch-free (direct flop outputs).

Reset
REQ-033 Asserting nvdla_core_rstn low SHALL asynchronously force state RST, counter 0, sync flops 0, pg_sleep=0, iso_en=1, dom_rstn=0, pwr_status=0, pwr_busy=1, pwr_err=0.
REQ-034 Reset assertion in any state, including PG_REQ/OFF, SHALL immediately release pg_sleep (power restored).
REQ-035 The post-reset sequence RST -> DEISO -> ON SHALL proceed without any request.

Verification
REQ-036 Power-on: rstn released, pwr_off_req=0 -> dom_rstn rises after 8 cycles, iso_en falls 4 cycles later, pwr_busy=0.
REQ-037 Power-down: pwr_off_req=1 in ON, pg_ack follows pg_sleep after 3 cycles -> iso_en=1/dom_rstn=0 next cycle, pg_sleep=1 4 cycles later, pwr_status=1 at ack+2 sync cycles.
REQ-038 Wake: pwr_off_req=0 in OFF -> pg_sleep=0 next cycle; after ack_s=0, 8 cycles RST, 4 cycles DEISO, then ON with iso_en=0.
REQ-039 Timeout: pg_ack stuck 0 in PG_REQ -> after 16 cycles pwr_err=1 and pg_sleep=0; pwr_err_clr pulse -> pwr_err=0.
REQ-040 Abort: pwr_off_req drops on the 2nd ISO cycle -> DEISO, pg_sleep never asserted, ON after 4 cycles.
REQ-041 Reset mid-OFF: rstn low while pwr_status=1 -> pg_sleep=0, iso_en=1, dom_rstn=0 immediately, without waiting for a clock edge.
